viterbi_symbol_packer: RTL and testbench

- Sits directly downstream of the global static stage of the Viterbi core.
- Each valid cycle it takes B_LEN decided symbols plus the global static energy for that cycle.
- It packs FRAME_LEN symbols into one frame and tags the frame with its peak energy and a threshold flag.
- Frames are buffered in a small FIFO and delivered over a valid/ready interface to the downstream checker/DSP consumer.

---
 rtl/viterbi_pack_pkg.sv | 24 ++
 rtl/symbol_frame_fifo.sv | 47 ++++
 rtl/viterbi_symbol_packer.sv | 132 +++++++++++++
 tb/tb_viterbi_symbol_packer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pack_pkg.sv
// Shared types for the Viterbi symbol packer: symbol encoding, frame entry layout
// and default geometry of the packed frame.
package viterbi_pack_pkg;

  localparam int PKG_B_LEN      = 2;
  localparam int PKG_B_WIDTH    = 8;
  localparam int PKG_FRAME_LEN  = 16;
  localparam int PKG_FIFO_DEPTH = 4;

  localparam int BATCHES_PER_FRAME = PKG_FRAME_LEN / PKG_B_LEN;

  typedef logic signed [1:0] sym_t;

  typedef struct packed {
    sym_t [PKG_FRAME_LEN-1:0]   symbols;
    logic [2*PKG_B_WIDTH-1:0]   max_energy;
    logic                       high_flag;
  } frame_entry_t;

  function automatic int batches_per_frame(input int frame_len, input int b_len);
    return frame_len / b_len;
  endfunction

endpackage

// File: rtl/symbol_frame_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always visible on pop_data.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module symbol_frame_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  // Extra pointer bit distinguishes full from empty when the slot indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/viterbi_symbol_packer.sv
// Packs B_LEN decided symbols per cycle into FRAME_LEN-symbol frames tagged with
// their peak energy and a threshold flag, and queues them for a valid/ready consumer.
module viterbi_symbol_packer
  import viterbi_pack_pkg::*;
#(
  parameter int B_LEN      = PKG_B_LEN,
  parameter int B_WIDTH    = PKG_B_WIDTH,
  parameter int FRAME_LEN  = PKG_FRAME_LEN,
  parameter int FIFO_DEPTH = PKG_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  sym_t [B_LEN-1:0]       final_symbols,
  input  logic [2*B_WIDTH-1:0]   global_static_energy,
  input  logic [2*B_WIDTH-1:0]   energy_thresh,
  input  logic                   frame_restart,
  input  logic                   clear_overflow,
  output logic                   out_valid,
  input  logic                   out_ready,
  output sym_t [FRAME_LEN-1:0]   out_frame,
  output logic [2*B_WIDTH-1:0]   out_max_energy,
  output logic                   out_high_energy,
  output logic                   overflow
);

  localparam int EW    = 2 * B_WIDTH;
  localparam int BPF   = batches_per_frame(FRAME_LEN, B_LEN);
  localparam int CNT_W = (BPF > 1) ? $clog2(BPF) : 1;

  generate
    if ((FRAME_LEN % B_LEN) != 0) begin : g_bad_frame_len
      $error("FRAME_LEN must be an integer multiple of B_LEN");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef struct packed {
    sym_t [FRAME_LEN-1:0] symbols;
    logic [EW-1:0]        max_energy;
    logic                 high_flag;
  } entry_t;

  function automatic logic [EW-1:0] umax(input logic [EW-1:0] a, input logic [EW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [CNT_W-1:0]     batch_cnt;
  sym_t [FRAME_LEN-1:0] part_frame;
  logic [EW-1:0]        run_max;
  logic                 overflow_q;

  logic                 first_batch;
  logic                 last_batch;
  sym_t [FRAME_LEN-1:0] frame_nxt;
  logic [EW-1:0]        max_nxt;
  logic                 push_req;
  logic                 ovf_set;
  entry_t               push_entry;
  entry_t               head_entry;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign first_batch = (batch_cnt == '0);
  assign last_batch  = (batch_cnt == CNT_W'(BPF - 1));

  // Oldest symbols drift toward the top index; the newest batch lands at [B_LEN-1:0].
  always_comb begin
    frame_nxt              = part_frame << (2 * B_LEN);
    frame_nxt[B_LEN-1:0]   = final_symbols;
  end

  assign max_nxt  = first_batch ? global_static_energy : umax(run_max, global_static_energy);
  assign push_req = in_valid && last_batch && !frame_restart;
  // A full FIFO is never empty, so out_ready alone tells whether a pop frees a slot.
  assign ovf_set  = push_req && fifo_full && !out_ready;

  assign push_entry.symbols    = frame_nxt;
  assign push_entry.max_energy = max_nxt;
  assign push_entry.high_flag  = (max_nxt > energy_thresh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batch_cnt  <= '0;
      part_frame <= '0;
      run_max    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (frame_restart) begin
        // A restart that lands on a completing batch discards that batch too.
        if (in_valid && !last_batch) begin
          part_frame <= frame_nxt;
          run_max    <= global_static_energy;
          batch_cnt  <= CNT_W'(1);
        end else begin
          batch_cnt  <= '0;
        end
      end else if (in_valid) begin
        part_frame <= frame_nxt;
        run_max    <= max_nxt;
        batch_cnt  <= last_batch ? '0 : batch_cnt + 1'b1;
      end

      if (ovf_set)             overflow_q <= 1'b1;
      else if (clear_overflow) overflow_q <= 1'b0;
    end
  end

  symbol_frame_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (push_entry),
    .pop       (out_ready),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head data is forced to zero while nothing is queued so reset leaves every output at 0.
  assign out_valid       = !fifo_empty;
  assign out_frame       = out_valid ? head_entry.symbols    : '0;
  assign out_max_energy  = out_valid ? head_entry.max_energy : '0;
  assign out_high_energy = out_valid && head_entry.high_flag;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_viterbi_symbol_packer.sv
// Directed and randomized bench for viterbi_symbol_packer (B_LEN=2, FRAME_LEN=8, depth 4)
// against a list-based frame model.
module tb_viterbi_symbol_packer;

  localparam int B_LEN     = 2;
  localparam int B_WIDTH   = 8;
  localparam int FRAME_LEN = 8;
  localparam int DEPTH     = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  final_symbols = '0;
  logic [15:0] ge = '0;
  logic [15:0] thr = '0;
  logic        frame_restart = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_frame;
  logic [15:0] out_max;
  logic        out_high;
  logic        ovf;

  int nvec = 0;
  int nerr = 0;

  typedef struct packed {
    logic [15:0] fr;
    logic [15:0] mx;
    logic        hi;
  } exp_t;

  exp_t        exp_q[$];
  logic [1:0]  psym[$];
  logic [15:0] pen[$];
  logic        m_ovf = 1'b0;

  always #5 clk = ~clk;

  viterbi_symbol_packer #(
    .B_LEN      (B_LEN),
    .B_WIDTH    (B_WIDTH),
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_valid             (in_valid),
    .final_symbols        (final_symbols),
    .global_static_energy (ge),
    .energy_thresh        (thr),
    .frame_restart        (frame_restart),
    .clear_overflow       (clear_overflow),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_frame            (out_frame),
    .out_max_energy       (out_max),
    .out_high_energy      (out_high),
    .overflow             (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    if (exp_q.size() > 0) begin
      chk("out_frame", 32'(out_frame), 32'(exp_q[0].fr));
      chk("out_max_energy", 32'(out_max), 32'(exp_q[0].mx));
      chk("out_high_energy", 32'(out_high), 32'(exp_q[0].hi));
    end
  endtask

  // Reference: symbols collected oldest-first; a full list becomes one frame.
  task automatic model_update();
    exp_t e;
    logic set_ovf;
    set_ovf = 1'b0;
    if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
    if (frame_restart) begin
      logic completing;
      completing = in_valid && (psym.size() == FRAME_LEN - B_LEN);
      psym.delete();
      pen.delete();
      if (in_valid && !completing) begin
        psym.push_back(final_symbols[3:2]);
        psym.push_back(final_symbols[1:0]);
        pen.push_back(ge);
      end
    end else if (in_valid) begin
      psym.push_back(final_symbols[3:2]);
      psym.push_back(final_symbols[1:0]);
      pen.push_back(ge);
      if (psym.size() == FRAME_LEN) begin
        e.fr = '0;
        for (int k = 0; k < FRAME_LEN; k++) e.fr[2*(FRAME_LEN-1-k) +: 2] = psym[k];
        e.mx = '0;
        foreach (pen[i]) if (pen[i] > e.mx) e.mx = pen[i];
        e.hi = (e.mx > thr);
        psym.delete();
        pen.delete();
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else set_ovf = 1'b1;
      end
    end
    if (set_ovf)             m_ovf = 1'b1;
    else if (clear_overflow) m_ovf = 1'b0;
  endtask

  task automatic step();
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic batch(input logic [1:0] s1, input logic [1:0] s0, input logic [15:0] e);
    in_valid      = 1'b1;
    final_symbols = {s1, s0};
    ge            = e;
    step();
    in_valid      = 1'b0;
  endtask

  task automatic rand_batch();
    batch(2'($urandom), 2'($urandom), 16'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_overflow", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Basic pack with energy tag above threshold
    out_ready = 1'b1;
    thr = 16'd256;
    batch(2'b01, 2'b11, 16'd10);
    batch(2'b01, 2'b01, 16'd300);
    batch(2'b11, 2'b11, 16'd20);
    batch(2'b11, 2'b01, 16'd40);
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_frame", 32'(out_frame), 32'h75FD);
    chk("basic_max", 32'(out_max), 32'd300);
    chk("basic_high", 32'(out_high), 32'd1);
    step();
    chk("basic_valid_drop", 32'(out_valid), 32'd0);
    idle(1);

    // Same energies, threshold equal to the peak
    thr = 16'd300;
    batch(2'b01, 2'b11, 16'd10);
    batch(2'b01, 2'b01, 16'd300);
    batch(2'b11, 2'b11, 16'd20);
    batch(2'b11, 2'b01, 16'd40);
    chk("thresh_eq_high", 32'(out_high), 32'd0);
    idle(2);

    // Backpressure: five frames into four slots
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) rand_batch();
    chk("ovf_set", 32'(ovf), 32'd1);
    out_ready = 1'b1;
    idle(6);
    chk("drained", 32'(out_valid), 32'd0);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'd0);

    // Full FIFO with a pop on the completing edge
    out_ready = 1'b0;
    for (int i = 0; i < 19; i++) rand_batch();
    out_ready = 1'b1;
    rand_batch();
    out_ready = 1'b0;
    chk("full_pop_no_ovf", 32'(ovf), 32'd0);
    idle(1);
    out_ready = 1'b1;
    idle(6);

    // Restart discards the partial frame; the restarting batch opens the new one
    batch(2'b11, 2'b11, 16'd5);
    batch(2'b10, 2'b10, 16'd6);
    frame_restart = 1'b1;
    batch(2'b01, 2'b01, 16'd7);
    frame_restart = 1'b0;
    for (int i = 0; i < 3; i++) rand_batch();
    chk("restart_valid", 32'(out_valid), 32'd1);
    chk("restart_head", 32'(out_frame[15:12]), 32'h5);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      final_symbols  = 4'($urandom);
      ge             = 16'($urandom);
      thr            = 16'($urandom);
      out_ready      = ($urandom_range(0, 2) != 0);
      clear_overflow = ($urandom_range(0, 15) == 0);
      frame_restart  = ($urandom_range(0, 19) == 0);
      step();
    end
    in_valid = 1'b0;
    frame_restart = 1'b0;
    out_ready = 1'b1;
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    idle(6);

    // Asynchronous reset with frames queued, overflow set and a partial frame
    out_ready = 1'b0;
    for (int i = 0; i < 21; i++) rand_batch();
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(out_valid), 32'd0);
    chk("async_reset_ovf", 32'(ovf), 32'd0);
    exp_q.delete();
    psym.delete();
    pen.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    chk("held_reset_valid", 32'(out_valid), 32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) rand_batch();
    chk("post_reset_one_frame", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    chk("post_reset_empty", 32'(out_valid), 32'd0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
